// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory
// request/ack channel plus decode handshake.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns fetch PC, one outstanding
// imem request, 2-entry instruction buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  fetch_unit_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_addr;
  logic        req_q;
  entry_t      fifo [2];
  logic [1:0]  count;
  logic        rd_ptr;

  logic [31:0] rpc;
  logic [31:0] pc_inc;
  logic        valid;
  logic        pop;
  logic        push;
  logic [1:0]  count_nx;
  logic        room;
  logic        wr_idx;

  assign rpc      = redirect_pc & ~32'h3;
  assign pc_inc   = fetch_pc + 32'd4;
  assign valid    = count != 2'd0;
  assign pop      = valid & bus.inst_ready
                  & ~redirect;
  assign push     = (state == REQ)
                  & bus.imem_ack & ~redirect;
  assign count_nx = redirect ? 2'd0 :
                    count + {1'b0, push}
                          - {1'b0, pop};
  assign room     = count_nx < 2'd2;
  assign wr_idx   = rd_ptr ^ count[0];

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = req_addr;
  assign bus.inst_valid = valid;
  assign bus.inst       = valid ?
                          fifo[rd_ptr].inst : NOP;
  assign bus.inst_pc    = valid ?
                          fifo[rd_ptr].pc : 32'd0;

  // Capture returned words at the buffer tail.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else if (push) begin
      fifo[wr_idx] <= '{pc:   bus.imem_addr,
                        inst: bus.imem_rdata};
    end
  end

  // Request FSM, fetch PC and buffer pointers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      req_q    <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
    end else begin
      count <= count_nx;
      if (redirect)
        rd_ptr <= 1'b0;
      else if (pop)
        rd_ptr <= ~rd_ptr;
      case (state)
        IDLE: begin
          if (redirect)
            fetch_pc <= rpc;
          if (room) begin
            state    <= REQ;
            req_q    <= 1'b1;
            req_addr <= redirect ? rpc : fetch_pc;
          end
        end
        REQ: begin
          if (redirect && bus.imem_ack) begin
            fetch_pc <= rpc;
            req_addr <= rpc;
          end else if (redirect) begin
            fetch_pc <= rpc;
            state    <= DROP;
          end else if (bus.imem_ack) begin
            fetch_pc <= pc_inc;
            if (room) begin
              req_addr <= pc_inc;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (redirect)
            fetch_pc <= rpc;
          if (bus.imem_ack) begin
            state    <= REQ;
            req_addr <= redirect ? rpc : fetch_pc;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: wait-state memory
// model plus in-order delivery scoreboard.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h100)) dut (
    .clock       (clock),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int wait_n = 0;
  int wcnt;
  int ack_cnt;
  int deliv = 0;
  bit sb_on = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] p_addr = 32'h0;
  logic        p_pend = 1'b0;

  function automatic logic [31:0] mdat(
    input logic [31:0] a);
    return (a * 32'd7) ^ 32'h5A5A_1234;
  endfunction

  assign bus.imem_ack = bus.imem_req &&
                        (wcnt >= wait_n);
  assign bus.imem_rdata = bus.imem_ack ?
                          mdat(bus.imem_addr) :
                          32'hDEAD_BEEF;

  // Memory wait-state counter and ack tally.
  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      wcnt    <= 0;
      ack_cnt <= 0;
    end else begin
      if (bus.imem_req && !bus.imem_ack)
        wcnt <= wcnt + 1;
      else
        wcnt <= 0;
      if (bus.imem_ack)
        ack_cnt <= ack_cnt + 1;
    end
  end

  // Address-hold check and delivery scoreboard.
  always @(negedge clock) begin
    logic [31:0] e;
    if (!rst) begin
      p_pend = 1'b0;
    end else begin
      if (p_pend) begin
        checks++;
        if (bus.imem_addr !== p_addr) begin
          failures++;
          $display("FAIL addr_hold got=%h exp=%h",
                   bus.imem_addr, p_addr);
        end
      end
      p_pend = bus.imem_req && !bus.imem_ack;
      p_addr = bus.imem_addr;
      if (sb_on && bus.inst_valid &&
          bus.inst_ready && !redirect) begin
        deliv++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_extra pc=%h exp=none",
                   bus.inst_pc);
        end else begin
          e = exp_q.pop_front();
          if (bus.inst_pc !== e ||
              bus.inst !== mdat(e)) begin
            failures++;
            $display("FAIL sb_order pc=%h inst=%h exp_pc=%h exp_inst=%h",
                     bus.inst_pc, bus.inst, e, mdat(e));
          end
        end
      end
    end
  end

  task automatic do_reset(input bit rdy);
    rst = 1'b0;
    sb_on = 1'b0;
    redirect = 1'b0;
    exp_q.delete();
    deliv = 0;
    bus.inst_ready = rdy;
    repeat (2) @(posedge clock);
    #2 rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.inst_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 ||
        bus.imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL rst_req req=%b addr=%h exp=0/00000100",
               bus.imem_req, bus.imem_addr);
    end
    checks++;
    if (bus.inst_valid !== 1'b0 ||
        bus.inst !== 32'h13 ||
        bus.inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL rst_out v=%b inst=%h pc=%h exp=0/00000013/0",
               bus.inst_valid, bus.inst, bus.inst_pc);
    end
  endtask

  task automatic test_stream();
    wait_n = 0;
    do_reset(1'b1);
    for (int i = 0; i < 16; i++)
      exp_q.push_back(32'(32'h100 + 4 * i));
    sb_on = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (bus.imem_req !== 1'b1 ||
        bus.imem_addr !== 32'h100 ||
        bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL str_e1 req=%b addr=%h v=%b exp=1/00000100/0",
               bus.imem_req, bus.imem_addr,
               bus.inst_valid);
    end
    @(posedge clock); #1;
    checks++;
    if (bus.imem_addr !== 32'h104 ||
        bus.inst_pc !== 32'h100) begin
      failures++;
      $display("FAIL str_e2 addr=%h pc=%h exp=104/100",
               bus.imem_addr, bus.inst_pc);
    end
    @(posedge clock); #1;
    checks++;
    if (bus.imem_addr !== 32'h108 ||
        bus.inst_pc !== 32'h104) begin
      failures++;
      $display("FAIL str_e3 addr=%h pc=%h exp=108/104",
               bus.imem_addr, bus.inst_pc);
    end
    repeat (8) @(posedge clock);
    #1;
    checks++;
    if (deliv !== 9) begin
      failures++;
      $display("FAIL str_rate got=%0d exp=9", deliv);
    end
  endtask

  task automatic test_backpressure();
    bit done;
    wait_n = 0;
    do_reset(1'b0);
    sb_on = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    checks++;
    if (ack_cnt !== 2 || bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL bp_full acks=%0d req=%b exp=2/0",
               ack_cnt, bus.imem_req);
    end
    checks++;
    if (bus.inst_valid !== 1'b1 ||
        bus.inst_pc !== 32'h100) begin
      failures++;
      $display("FAIL bp_head v=%b pc=%h exp=1/100",
               bus.inst_valid, bus.inst_pc);
    end
    for (int i = 0; i < 8; i++)
      exp_q.push_back(32'(32'h100 + 4 * i));
    bus.inst_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clock); #1;
      if (deliv >= 3) done = 1'b1;
    end
    bus.inst_ready = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL bp_resume got=%0d exp>=3", deliv);
    end
  endtask

  task automatic test_redirect_drop();
    bit found;
    wait_n = 3;
    do_reset(1'b1);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    sb_on = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clock); #1;
      if (bus.imem_req && !bus.imem_ack &&
          bus.imem_addr == 32'h108 &&
          !bus.inst_valid)
        found = 1'b1;
    end
    checks++;
    if (!found || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drp_pend found=%b left=%0d exp=1/0",
               found, exp_q.size());
    end
    for (int i = 0; i < 8; i++)
      exp_q.push_back(32'(32'h2000 + 4 * i));
    redirect = 1'b1;
    redirect_pc = 32'h2000;
    @(posedge clock); #1;
    redirect = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b0 ||
        bus.imem_req !== 1'b1 ||
        bus.imem_addr !== 32'h108) begin
      failures++;
      $display("FAIL drp_hold v=%b req=%b addr=%h exp=0/1/108",
               bus.inst_valid, bus.imem_req,
               bus.imem_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clock); #1;
      if (bus.imem_addr != 32'h108) found = 1'b1;
    end
    checks++;
    if (bus.imem_addr !== 32'h2000) begin
      failures++;
      $display("FAIL drp_addr got=%h exp=2000",
               bus.imem_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clock); #1;
      if (bus.inst_valid) found = 1'b1;
    end
    bus.inst_ready = 1'b0;
    checks++;
    if (bus.inst_pc !== 32'h2000) begin
      failures++;
      $display("FAIL drp_first got=%h exp=2000",
               bus.inst_pc);
    end
  endtask

  task automatic test_redirect_ack();
    bit found;
    wait_n = 0;
    do_reset(1'b1);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    sb_on = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clock); #1;
      if (bus.imem_addr == 32'h110) found = 1'b1;
    end
    checks++;
    if (!found || bus.imem_ack !== 1'b1 ||
        exp_q.size() != 0) begin
      failures++;
      $display("FAIL rack_pre found=%b ack=%b left=%0d exp=1/1/0",
               found, bus.imem_ack, exp_q.size());
    end
    for (int i = 0; i < 8; i++)
      exp_q.push_back(32'(32'h40 + 4 * i));
    redirect = 1'b1;
    redirect_pc = 32'h41;
    @(posedge clock); #1;
    redirect = 1'b0;
    checks++;
    if (bus.imem_addr !== 32'h40 ||
        bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL rack_addr addr=%h v=%b exp=40/0",
               bus.imem_addr, bus.inst_valid);
    end
    @(posedge clock); #1;
    bus.inst_ready = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b1 ||
        bus.inst_pc !== 32'h40 ||
        bus.inst !== mdat(32'h40)) begin
      failures++;
      $display("FAIL rack_first v=%b pc=%h inst=%h exp=1/40/%h",
               bus.inst_valid, bus.inst_pc,
               bus.inst, mdat(32'h40));
    end
  endtask

  task automatic test_wrap();
    wait_n = 0;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    @(posedge clock); #1;
    bus.inst_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    @(posedge clock); #1;
    redirect = 1'b0;
    checks++;
    if (bus.imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_top got=%h exp=fffffffc",
               bus.imem_addr);
    end
    @(posedge clock); #1;
    checks++;
    if (bus.imem_addr !== 32'h0 ||
        bus.inst_pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_zero addr=%h pc=%h exp=0/fffffffc",
               bus.imem_addr, bus.inst_pc);
    end
    @(posedge clock); #1;
    bus.inst_ready = 1'b0;
    checks++;
    if (bus.inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pc got=%h exp=0",
               bus.inst_pc);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    wait_n = 4;
    do_reset(1'b0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clock); #1;
      if (bus.inst_valid && bus.imem_req)
        found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rmid_setup got=0 exp=1");
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 ||
        bus.imem_addr !== 32'h100 ||
        bus.inst_valid !== 1'b0 ||
        bus.inst !== 32'h13 ||
        bus.inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL rmid_out req=%b addr=%h v=%b inst=%h pc=%h",
               bus.imem_req, bus.imem_addr,
               bus.inst_valid, bus.inst, bus.inst_pc);
    end
    wait_n = 0;
    do_reset(1'b1);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    sb_on = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (bus.imem_req !== 1'b1 ||
        bus.imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL rmid_restart req=%b addr=%h exp=1/100",
               bus.imem_req, bus.imem_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clock); #1;
      if (deliv >= 1) found = 1'b1;
    end
    bus.inst_ready = 1'b0;
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rmid_deliv got=%0d exp>=1",
               deliv);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
